// File: rtl/auth_msg_arbiter.sv
// -----------------------------------------------------------------------------
// auth_msg_arbiter
//   Shares one outgoing authentication message channel between NUM_REQ
//   initiator controllers (digests, certificate, challenge). One requester at a
//   time is granted in round-robin order. Its request word is forwarded to the
//   channel, the responder's reply is awaited, and the reply is routed back with
//   a done pulse. If no reply arrives within TIMEOUT_CYC cycles, the transaction
//   ends with a timeout pulse instead. All outputs are registered.
//
// Ports
//   clk          system clock, posedge
//   reset        asynchronous active-low reset
//   req          per-requester request level
//   req_msg      request words, slice i = [i*MSG_W +: MSG_W]
//   tx_ack       channel accepted tx_msg
//   rsp_valid    responder reply present (1-cycle qualifier)
//   rsp_msg      responder reply word
//   grant        one-hot owner of the channel, 0 when free
//   tx_valid     tx_msg valid toward channel
//   tx_msg       request word of the granted requester
//   rsp_data     last routed reply, held until the next reply
//   done         1-cycle pulse, reply for requester i is on rsp_data
//   timeout_err  1-cycle pulse, requester i timed out
//   busy         arbiter is not idle
//
// State     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | channel free, round-robin search over req each cycle
// SEND      | tx_valid up, waiting for tx_ack (owner dropping req aborts)
// WAIT_RSP  | request accepted, timer counts toward the timeout
// DELIVER   | reply captured on rsp_data, done pulse is out
// RELEASE   | grant held until the owner drops its req
// -----------------------------------------------------------------------------
module auth_msg_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int MSG_W       = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*MSG_W-1:0] req_msg,
  input  logic                     tx_ack,
  input  logic                     rsp_valid,
  input  logic [MSG_W-1:0]         rsp_msg,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     tx_valid,
  output logic [MSG_W-1:0]         tx_msg,
  output logic [MSG_W-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       timeout_err,
  output logic                     busy
);

  localparam int               IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]       TIMER_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] PTR_RST    = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_RSP,
    DELIVER,
    RELEASE
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [IDX_W-1:0]   pick_idx, cand;
  logic               pick_found;
  logic [7:0]         timer, timer_nxt;
  logic [NUM_REQ-1:0] grant_nxt, done_nxt, timeout_nxt;
  logic               tx_valid_nxt;
  logic [MSG_W-1:0]   tx_msg_nxt, rsp_data_nxt;

  // Round-robin search: first requester strictly after the last owner, with wrap.
  always_comb begin : rr_search
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin : fsm_next
    state_nxt    = state;
    owner_nxt    = owner;
    ptr_nxt      = ptr;
    timer_nxt    = timer;
    grant_nxt    = grant;
    tx_valid_nxt = tx_valid;
    tx_msg_nxt   = tx_msg;
    rsp_data_nxt = rsp_data;
    done_nxt     = '0;
    timeout_nxt  = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          owner_nxt           = pick_idx;
          grant_nxt           = '0;
          grant_nxt[pick_idx] = 1'b1;
          tx_msg_nxt          = req_msg[int'(pick_idx)*MSG_W +: MSG_W];
          tx_valid_nxt        = 1'b1;
          state_nxt           = SEND;
        end
      end
      SEND: begin
        // An ack in the same cycle as the owner's req drop still commits.
        if (tx_ack) begin
          tx_valid_nxt = 1'b0;
          timer_nxt    = '0;
          state_nxt    = WAIT_RSP;
        end else if (!req[owner]) begin
          tx_valid_nxt = 1'b0;
          grant_nxt    = '0;
          ptr_nxt      = owner;
          state_nxt    = IDLE;
        end
      end
      WAIT_RSP: begin
        timer_nxt = timer + 8'd1;
        // A reply on the last allowed cycle beats the timeout.
        if (rsp_valid) begin
          rsp_data_nxt    = rsp_msg;
          done_nxt[owner] = 1'b1;
          state_nxt       = DELIVER;
        end else if (timer == TIMER_LAST) begin
          timeout_nxt[owner] = 1'b1;
          state_nxt          = RELEASE;
        end
      end
      DELIVER: begin
        state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!req[owner]) begin
          grant_nxt = '0;
          ptr_nxt   = owner;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= '0;
      ptr         <= PTR_RST;
      timer       <= '0;
      grant       <= '0;
      tx_valid    <= 1'b0;
      tx_msg      <= '0;
      rsp_data    <= '0;
      done        <= '0;
      timeout_err <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      ptr         <= ptr_nxt;
      timer       <= timer_nxt;
      grant       <= grant_nxt;
      tx_valid    <= tx_valid_nxt;
      tx_msg      <= tx_msg_nxt;
      rsp_data    <= rsp_data_nxt;
      done        <= done_nxt;
      timeout_err <= timeout_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_auth_msg_arbiter.sv
module tb_auth_msg_arbiter;

  localparam int N  = 3;
  localparam int W  = 64;
  localparam int TO = 8;

  localparam int EV_TX    = 0;
  localparam int EV_TXEND = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_TO    = 3;
  localparam int EV_REL   = 4;

  localparam int K_NORMAL  = 0;
  localparam int K_TIMEOUT = 1;
  localparam int K_ABORT   = 2;
  localparam int K_ACKDROP = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_msg = '0;
  logic           tx_ack = 1'b0;
  logic           rsp_valid = 1'b0;
  logic [W-1:0]   rsp_msg = '0;
  logic [N-1:0]   grant;
  logic           tx_valid;
  logic [W-1:0]   tx_msg;
  logic [W-1:0]   rsp_data;
  logic [N-1:0]   done;
  logic [N-1:0]   timeout_err;
  logic           busy;

  auth_msg_arbiter #(.NUM_REQ(N), .MSG_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_msg(req_msg),
    .tx_ack(tx_ack), .rsp_valid(rsp_valid), .rsp_msg(rsp_msg),
    .grant(grant), .tx_valid(tx_valid), .tx_msg(tx_msg), .rsp_data(rsp_data),
    .done(done), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           kind;
    int           idx;
    logic [W-1:0] data;
    int           stamp;
  } ev_t;

  ev_t          exp_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           ptr_m = N - 1;
  logic [W-1:0] last_rsp = '0;
  logic [N-1:0] prev_grant = '0;
  logic         prev_txv = 1'b0;

  function automatic string kname(int k);
    case (k)
      EV_TX:    return "tx";
      EV_TXEND: return "tx_end";
      EV_DONE:  return "done";
      EV_TO:    return "timeout";
      default:  return "release";
    endcase
  endfunction

  function automatic logic [N-1:0] onehot(int i);
    return N'(1) << i;
  endfunction

  function automatic void push(int kind, int idx, logic [W-1:0] data, int stamp);
    ev_t e;
    e.kind  = kind;
    e.idx   = idx;
    e.data  = data;
    e.stamp = stamp;
    exp_q.push_back(e);
  endfunction

  // Reference arbitration: first requester after the previous owner, wrapping.
  function automatic int rr_pick(logic [N-1:0] rq);
    for (int k = 1; k <= N; k++)
      if (rq[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return 0;
  endfunction

  function automatic void pop_check(int kind, logic [N-1:0] vec, logic [W-1:0] data);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_%s: got vec=%b data=%h at cyc %0d, required no event",
               kname(kind), vec, data, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind == EV_DONE) last_rsp = e.data;
    if (e.kind != kind || e.stamp != cyc || vec != onehot(e.idx) || data != e.data) begin
      miscompares++;
      $display("FAIL %s_event: got %s vec=%b data=%h cyc %0d, required %s vec=%b data=%h cyc %0d",
               kname(e.kind), kname(kind), vec, data, cyc,
               kname(e.kind), onehot(e.idx), e.data, e.stamp);
    end
  endfunction

  // Monitor: turns output activity into events and matches them against the queue.
  always @(negedge clk) begin
    if (!reset) begin
      prev_grant = '0;
      prev_txv   = 1'b0;
    end else begin
      if (tx_valid && !prev_txv)         pop_check(EV_TX, grant, tx_msg);
      if (!tx_valid && prev_txv)         pop_check(EV_TXEND, prev_grant, '0);
      if (done != '0)                    pop_check(EV_DONE, done, rsp_data);
      if (timeout_err != '0)             pop_check(EV_TO, timeout_err, '0);
      if (grant == '0 && prev_grant != '0) pop_check(EV_REL, prev_grant, '0);
      while (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.kind == EV_DONE) last_rsp = e.data;
        vectors++;
        miscompares++;
        $display("FAIL missing_%s: got nothing by cyc %0d, required vec=%b data=%h at cyc %0d",
                 kname(e.kind), cyc, onehot(e.idx), e.data, e.stamp);
      end
      vectors++;
      if (!$onehot0(grant) || !$onehot0(done) || !$onehot0(timeout_err) ||
          (done != '0 && timeout_err != '0) || (busy != (grant != '0)) ||
          (tx_valid && grant == '0)) begin
        miscompares++;
        $display("FAIL invariants: got grant=%b done=%b timeout_err=%b busy=%b tx_valid=%b at cyc %0d, required onehot0/exclusive/busy==|grant",
                 grant, done, timeout_err, busy, tx_valid, cyc);
      end
      vectors++;
      if (rsp_data !== last_rsp) begin
        miscompares++;
        $display("FAIL rsp_data_hold: got %h at cyc %0d, required %h", rsp_data, cyc, last_rsp);
      end
      prev_grant = grant;
      prev_txv   = tx_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_zero(input string name);
    logic [159:0] got;
    got = 160'({grant, tx_valid, tx_msg, rsp_data, done, timeout_err, busy});
    vectors++;
    if (got != '0) begin
      miscompares++;
      $display("FAIL %s: got outputs=%h at cyc %0d, required all zero", name, got, cyc);
    end
  endtask

  // One transaction, entered right after an edge that left the arbiter idle.
  task automatic run_txn(input logic [N-1:0] rq, input int kind, input int ack_dly,
                         input int rsp_dly, input int hold, input logic [W-1:0] rsp_word,
                         input bit use_txm, input logic [W-1:0] txm);
    int           own, k, x, s, r;
    logic [N-1:0] m;
    req = rq;
    for (int i = 0; i < N; i++) req_msg[i*W +: W] = {$urandom, $urandom};
    own = rr_pick(rq);
    m   = onehot(own);
    if (use_txm) req_msg[own*W +: W] = txm;
    push(EV_TX, own, req_msg[own*W +: W], cyc + 1);
    tick();
    for (int i = 0; i < ack_dly; i++) begin
      rsp_valid = 1'($urandom_range(0, 1));
      rsp_msg   = {$urandom, $urandom};
      tick();
    end
    rsp_valid = 1'b0;
    if (kind == K_ABORT) begin
      req = req & ~m;
      push(EV_TXEND, own, '0, cyc + 1);
      push(EV_REL, own, '0, cyc + 1);
      ptr_m = own;
      tick();
      return;
    end
    tx_ack = 1'b1;
    if (kind == K_ACKDROP) req = req & ~m;
    push(EV_TXEND, own, '0, cyc + 1);
    tick();
    tx_ack = 1'b0;
    k = cyc;
    req = (req & m) | (N'($urandom) & ~m);
    if (kind == K_TIMEOUT) begin
      x = k + TO;
      push(EV_TO, own, '0, x);
      while (cyc < x) tick();
    end else begin
      for (int i = 1; i < rsp_dly; i++) tick();
      rsp_valid = 1'b1;
      rsp_msg   = rsp_word;
      x = cyc + 1;
      push(EV_DONE, own, rsp_word, x);
      tick();
      rsp_valid = 1'b0;
    end
    // Release happens on the first edge the arbiter is in RELEASE with the
    // owner's req low: one edge after a timeout, two edges after a reply.
    s = x + hold;
    if (kind == K_TIMEOUT)      r = (s + 1 > x + 1) ? s + 1 : x + 1;
    else if (kind == K_ACKDROP) r = x + 2;
    else                        r = (s + 1 > x + 2) ? s + 1 : x + 2;
    push(EV_REL, own, '0, r);
    ptr_m = own;
    while (cyc < r) begin
      if (cyc >= s) req = req & ~m;
      rsp_valid = (kind == K_TIMEOUT && cyc == x);
      rsp_msg   = {$urandom, $urandom};
      tick();
    end
    rsp_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test by cyc %0d, required completion", cyc);
    $fatal(1);
  end

  initial begin
    int own;
    // T1: reset state and quiet idle
    tick(); tick(); tick();
    check_zero("reset_state");
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_zero("idle_after_reset");
    end

    // T3: all requesting, round-robin from the reset pointer
    for (int i = 0; i < 4; i++)
      run_txn(3'b111, K_NORMAL, $urandom_range(0, 2), $urandom_range(1, 5),
              $urandom_range(0, 1), {$urandom, $urandom}, 1'b0, '0);
    idle(2);

    // T2: directed single transaction
    run_txn(3'b001, K_NORMAL, 2, 3, 1, 64'h0101_8200_0000_00AA, 1'b1, 64'h0101_8100_0000_0001);
    idle(2);

    // T4: timeout, late reply ignored
    run_txn(3'b010, K_TIMEOUT, 1, 0, 2, '0, 1'b0, '0);
    idle(1);

    // T5: reply on the timeout cycle, abort in SEND, ack together with drop
    run_txn(3'b100, K_NORMAL, 0, TO, 0, {$urandom, $urandom}, 1'b0, '0);
    run_txn(3'b011, K_ABORT, 1, 0, 0, '0, 1'b0, '0);
    idle(1);
    run_txn(3'b101, K_ACKDROP, 0, 2, 0, {$urandom, $urandom}, 1'b0, '0);
    run_txn(3'b110, K_ABORT, 0, 0, 0, '0, 1'b0, '0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      run_txn(N'($urandom_range(1, 7)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(1, TO)),
              int'($urandom_range(0, 2)), {$urandom, $urandom}, 1'b0, '0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end

    // T6: asynchronous reset in WAIT_RSP, then a fresh grant
    req = 3'b100;
    for (int i = 0; i < N; i++) req_msg[i*W +: W] = {$urandom, $urandom};
    own = rr_pick(3'b100);
    push(EV_TX, own, req_msg[own*W +: W], cyc + 1);
    tick();
    tx_ack = 1'b1;
    push(EV_TXEND, own, '0, cyc + 1);
    tick();
    tx_ack = 1'b0;
    tick();
    tick();
    #2 reset = 1'b0;
    #1 check_zero("async_reset");
    exp_q.delete();
    ptr_m    = N - 1;
    last_rsp = '0;
    req      = '0;
    tick();
    tick();
    reset = 1'b1;
    idle(2);
    run_txn(3'b010, K_NORMAL, 1, 2, 0, {$urandom, $urandom}, 1'b0, '0);
    idle(4);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_events: got %0d still queued at end, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
